// File: rtl/seq_multiplier_param.sv
// Parametrised shift-and-add multiplier with start/ready/done handshake and signed/unsigned mode.
// Optional SEQ_MULT_EARLY_EXIT_EN: leave the SHIFT loop as soon as the remaining multiplier is zero.
module seq_multiplier_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   count;
    logic            neg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] mplier_shr;
    logic             early_exit;

    // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude.
    always_comb begin
        a_mag      = (signed_mode && a_in[WIDTH-1]) ? -a_in : a_in;
        b_mag      = (signed_mode && b_in[WIDTH-1]) ? -b_in : b_in;
        mplier_shr = mplier >> 1;
    end

`ifdef SEQ_MULT_EARLY_EXIT_EN
    assign early_exit = (mplier_shr == '0);
`else
    assign early_exit = 1'b0;
`endif

    // NOTE: state and registered outputs share one clocked block and use non-blocking
    // assignments only, so every branch reads the pre-edge register values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            count   <= '0;
            neg     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        count  <= CW'(WIDTH - 1);
                        neg    <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        ready  <= 1'b0;
                        state  <= b_mag[0] ? S_ADD : S_SHIFT;
                    end
                end
                S_ADD: begin
                    acc   <= acc + mcand;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier_shr;
                    if (count == '0 || early_exit) begin
                        state <= S_FIX;
                    end else begin
                        count <= count - CW'(1);
                        state <= mplier_shr[0] ? S_ADD : S_SHIFT;
                    end
                end
                S_FIX: begin
                    product <= neg ? -acc : acc;
                    done    <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed self-checking bench for seq_multiplier_param: 8-bit and 16-bit instances.
// Expected latencies follow SEQ_MULT_EARLY_EXIT_EN when the bench is built with it.
module tb_seq_multiplier_param;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, done8;
    logic [15:0] product8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ready16, done16;
    logic [31:0] product16;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    seq_multiplier_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
        .a_in(a8), .b_in(b8), .ready(ready8), .done(done8), .product(product8)
    );

    seq_multiplier_param #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .signed_mode(sm16),
        .a_in(a16), .b_in(b16), .ready(ready16), .done(done16), .product(product16)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Latencies are written out per vector: normal build vs early-exit build.
    function automatic int pick(input int normal_lat, input int early_lat);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        return early_lat;
`else
        return normal_lat;
`endif
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the first IDLE cycle.
    task automatic run8(input string tag, input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_p, input int exp_lat, input bit poke);
        logic [15:0] old_p;
        int lat;
        int bad;
        check({tag, "_ready_before"}, 32'(ready8), 32'd1);
        old_p  = product8;
        start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        @(posedge clk);
        #1;
        start8 = 1'b0; sm8 = ~sm; a8 = ~a; b8 = 8'h5A;
        lat = 0;
        bad = 0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (done8) begin
                lat = n;
                break;
            end
            if (ready8 !== 1'b0 || product8 !== old_p) bad++;
            if (poke && (n == 3 || n == 7)) begin
                start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
            end else begin
                start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_hold"}, 32'(bad), 32'd0);
        check({tag, "_ready_in_done"}, 32'(ready8), 32'd0);
        check({tag, "_product"}, 32'(product8), 32'(exp_p));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done8), 32'd0);
        check({tag, "_ready_after"}, 32'(ready8), 32'd1);
        check({tag, "_product_held"}, 32'(product8), 32'(exp_p));
    endtask

    task automatic run16(input string tag, input logic sm, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_p, input int exp_lat);
        int lat;
        check({tag, "_ready_before"}, 32'(ready16), 32'd1);
        start16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
        @(posedge clk);
        #1;
        start16 = 1'b0; sm16 = ~sm; a16 = 16'h1234; b16 = 16'h00FF;
        lat = 0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (done16) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_product"}, product16, exp_p);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done16), 32'd0);
    endtask

    initial begin
        int lat;

        // Reset state while reset is held.
        repeat (2) @(negedge clk);
        check("rst_ready8", 32'(ready8), 32'd1);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_product8", 32'(product8), 32'd0);
        check("rst_ready16", 32'(ready16), 32'd1);
        check("rst_product16", product16, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run8("u_3x5", 1'b0, 8'd3, 8'd5, 16'd15, pick(12, 7), 1'b0);
        run8("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000, pick(11, 11), 1'b0);
        run8("s_m3x7", 1'b1, 8'hFD, 8'h07, 16'hFFEB, pick(13, 8), 1'b0);
        run8("u_255x255", 1'b0, 8'hFF, 8'hFF, 16'hFE01, pick(18, 18), 1'b1);
        run8("u_12x0", 1'b0, 8'h12, 8'h00, 16'h0000, pick(10, 3), 1'b0);
        run8("u_2x2_b2b", 1'b0, 8'd2, 8'd2, 16'd4, pick(11, 5), 1'b0);

        // Reset asserted during the 4th SHIFT cycle of 9 x 9 (cycle 6 of the operation).
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'd9; b8 = 8'd9;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready8), 32'd1);
        check("midrst_done", 32'(done8), 32'd0);
        check("midrst_product", 32'(product8), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run8("u_9x9_after_rst", 1'b0, 8'd9, 8'd9, 16'd81, pick(12, 8), 1'b0);

        run16("w16_s_m1x1", 1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF, pick(19, 4));
        run16("w16_u_ffffx1", 1'b0, 16'hFFFF, 16'h0001, 32'h0000_FFFF, pick(19, 4));

        lat = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
